// File: rtl/simd_mem_arbiter.sv
// rtl/simd_mem_arbiter.sv - round-robin scalar/vector arbiter onto one word-wide memory port
// Optional SIMD_ARB_TIMEOUT_EN adds an M_ACK watchdog and a sticky ERR output.
module simd_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int VEC_DATA_WIDTH = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      S_REQ,
    input  logic                      S_WE,
    input  logic [ADDR_WIDTH-1:0]     S_ADDR,
    input  logic [DATA_WIDTH-1:0]     S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_WMASK,
    output logic [DATA_WIDTH-1:0]     S_RDATA,
    output logic                      S_ACK,
    input  logic                      V_REQ,
    input  logic                      V_WE,
    input  logic [ADDR_WIDTH-1:0]     V_ADDR,
    input  logic [VEC_DATA_WIDTH-1:0] V_WDATA,
    output logic [VEC_DATA_WIDTH-1:0] V_RDATA,
    output logic                      V_ACK,
    output logic                      M_REQ,
    output logic                      M_WE,
    output logic [ADDR_WIDTH-1:0]     M_ADDR,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WMASK,
    input  logic                      M_ACK,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    output logic                      BUSY
`ifdef SIMD_ARB_TIMEOUT_EN
    ,
    output logic                      ERR
`endif
);

    localparam int BEATS  = VEC_DATA_WIDTH / DATA_WIDTH;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

    if ((VEC_DATA_WIDTH % DATA_WIDTH) != 0 || BEATS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("simd_mem_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SXFER, VXFER, RESP} state_t;

    state_t                    state;
    state_t                    next_state;
    logic                      any_req;
    logic                      grant_vec;
    logic                      m_req;
    logic                      to_hit;
    logic                      owner_vec;
    logic                      prefer_vec;
    logic                      lat_we;
    logic [ADDR_WIDTH-1:0]     lat_addr;
    logic [VEC_DATA_WIDTH-1:0] lat_wdata;
    logic [BYTES-1:0]          lat_wmask;
    logic [BEAT_W-1:0]         beat;
    logic [ADDR_WIDTH-1:0]     beat_off;
    logic [DATA_WIDTH-1:0]     s_rdata_q;
    logic [VEC_DATA_WIDTH-1:0] v_rdata_q;

    assign any_req   = S_REQ || V_REQ;
    // With both pending, the port that did not win last time goes first.
    assign grant_vec = (S_REQ && V_REQ) ? prefer_vec : V_REQ;
    assign m_req     = (state == SXFER) || (state == VXFER);
    assign beat_off  = ADDR_WIDTH'(beat) * ADDR_WIDTH'(BYTES);

`ifdef SIMD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign to_hit = m_req && !M_ACK && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign ERR    = err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (m_req && !M_ACK && !to_hit)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
            if (to_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req)
                    next_state = grant_vec ? VXFER : SXFER;
            end
            SXFER: begin
                if (M_ACK || to_hit)
                    next_state = RESP;
            end
            VXFER: begin
                if ((M_ACK && beat == LAST_BEAT) || to_hit)
                    next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        M_REQ   = 1'b0;
        M_WE    = 1'b0;
        M_ADDR  = '0;
        M_WDATA = '0;
        M_WMASK = '0;
        S_ACK   = 1'b0;
        V_ACK   = 1'b0;
        if (m_req) begin
            M_REQ   = 1'b1;
            M_WE    = lat_we;
            M_ADDR  = lat_addr + beat_off;
            M_WDATA = lat_wdata[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
            M_WMASK = lat_wmask;
        end
        if (state == RESP) begin
            S_ACK = !owner_vec;
            V_ACK = owner_vec;
        end
    end

    assign BUSY    = (state != IDLE);
    assign S_RDATA = s_rdata_q;
    assign V_RDATA = v_rdata_q;

    // Read data is zeroed at grant so beats lost to a watchdog abort read back as 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner_vec  <= 1'b0;
            prefer_vec <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            beat       <= '0;
            s_rdata_q  <= '0;
            v_rdata_q  <= '0;
        end else if (state == IDLE && any_req) begin
            owner_vec  <= grant_vec;
            prefer_vec <= !grant_vec;
            beat       <= '0;
            if (grant_vec) begin
                lat_we    <= V_WE;
                lat_addr  <= V_ADDR & ALIGN_MASK;
                lat_wdata <= V_WDATA;
                lat_wmask <= '1;
                if (!V_WE)
                    v_rdata_q <= '0;
            end else begin
                lat_we    <= S_WE;
                lat_addr  <= S_ADDR & ALIGN_MASK;
                lat_wdata <= VEC_DATA_WIDTH'(S_WDATA);
                lat_wmask <= S_WMASK;
                if (!S_WE)
                    s_rdata_q <= '0;
            end
        end else if (m_req && M_ACK) begin
            if (!lat_we) begin
                if (owner_vec)
                    v_rdata_q[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= M_RDATA;
                else
                    s_rdata_q <= M_RDATA;
            end
            if (state == VXFER && beat != LAST_BEAT)
                beat <= beat + BEAT_W'(1);
        end
    end

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// tb/tb_simd_mem_arbiter.sv - randomized self-checking bench for simd_mem_arbiter
// Build with SIMD_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_simd_mem_arbiter;

    localparam int BEATS = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_req, s_we, s_ack;
    logic [63:0]  s_addr, s_wdata, s_rdata;
    logic [7:0]   s_wmask;
    logic         v_req, v_we, v_ack;
    logic [63:0]  v_addr;
    logic [511:0] v_wdata, v_rdata;
    logic         m_req, m_we, m_ack, busy;
    logic [63:0]  m_addr, m_wdata, m_rdata;
    logic [7:0]   m_wmask;
`ifdef SIMD_ARB_TIMEOUT_EN
    logic         err;
`endif

    simd_mem_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .VEC_DATA_WIDTH(512), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(clk), .RESET(reset),
        .S_REQ(s_req), .S_WE(s_we), .S_ADDR(s_addr), .S_WDATA(s_wdata), .S_WMASK(s_wmask),
        .S_RDATA(s_rdata), .S_ACK(s_ack),
        .V_REQ(v_req), .V_WE(v_we), .V_ADDR(v_addr), .V_WDATA(v_wdata),
        .V_RDATA(v_rdata), .V_ACK(v_ack),
        .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_WMASK(m_wmask),
        .M_ACK(m_ack), .M_RDATA(m_rdata), .BUSY(busy)
`ifdef SIMD_ARB_TIMEOUT_EN
        , .ERR(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } xfer_t;

    xfer_t        xq[$];
    logic [63:0]  mem [logic [63:0]];
    int           max_delay = 0;
    bit           hold_ack = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;
    bit           last_grant_vec = 1'b1;
    logic [63:0]  s_rd_model = '0;
    logic [511:0] v_rd_model = '0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a))
            return mem[a];
        return {a[31:0] ^ 32'h5a5a_5a5a, ~a[31:0]};
    endfunction

    // Memory: random wait states, logs every accepted transfer, noise on M_ACK while idle.
    initial begin
        bit          in_beat;
        int          wait_left;
        xfer_t       x;
        logic [63:0] bm;
        in_beat = 1'b0;
        wait_left = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            m_rdata = {$urandom, $urandom};
            if (m_req && !hold_ack) begin
                if (!in_beat) begin
                    in_beat = 1'b1;
                    wait_left = $urandom_range(0, max_delay);
                end
                if (wait_left == 0) begin
                    x.addr = m_addr; x.we = m_we; x.wdata = m_wdata; x.mask = m_wmask;
                    xq.push_back(x);
                    if (m_we) begin
                        for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{m_wmask[b]}};
                        mem[m_addr] = (mem_rd(m_addr) & ~bm) | (m_wdata & bm);
                    end else begin
                        m_rdata = mem_rd(m_addr);
                    end
                    m_ack = 1'b1;
                    in_beat = 1'b0;
                end else begin
                    wait_left--;
                end
            end else if (!m_req) begin
                in_beat = 1'b0;
                m_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic run_txn(input bit is_vec, input bit we, input logic [63:0] addr,
                           input logic [511:0] wdata, input logic [7:0] wmask,
                           input bit solo, output time ack_time);
        int           n, cycles, mcyc, gaps;
        bit           got, scrambled;
        logic [63:0]  base;
        logic [511:0] exp_rd;
        xfer_t        x;
        string        tg;
        n = is_vec ? BEATS : 1;
        base = addr & ~64'h7;
        tg = is_vec ? "vec" : "sca";
        @(posedge clk); #1;
        if (is_vec) begin
            v_we = we; v_addr = addr; v_wdata = wdata; v_req = 1'b1;
        end else begin
            s_we = we; s_addr = addr; s_wdata = wdata[63:0]; s_wmask = wmask; s_req = 1'b1;
        end
        cycles = 0; mcyc = 0; gaps = 0; got = 1'b0; scrambled = 1'b0; ack_time = 0;
        while (!got && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (is_vec ? v_ack : s_ack) got = 1'b1;
            else if (s_ack || v_ack) begin mcyc = 0; gaps = 0; end
            else if (busy && m_req) mcyc++;
            else if (busy) gaps++;
            // Once granted, the request fields must no longer matter.
            if (solo && busy && !got && !scrambled) begin
                scrambled = 1'b1;
                if (is_vec) begin
                    v_we = 1'($urandom); v_addr = {$urandom, $urandom}; v_wdata = {16{$urandom}};
                end else begin
                    s_we = 1'($urandom); s_addr = {$urandom, $urandom};
                    s_wdata = {$urandom, $urandom}; s_wmask = 8'($urandom);
                end
            end
        end
        check({tg, "_ack_seen"}, got, 1);
        if (got) begin
            ack_time = $time;
            check({tg, "_ack_excl_mreq_low"}, {m_req, (is_vec ? s_ack : v_ack)}, 0);
            check({tg, "_mreq_gaps"}, gaps, 0);
            if (max_delay == 0) check({tg, "_mreq_cycles"}, mcyc, n);
            if (solo && max_delay == 0) check({tg, "_req_to_ack"}, cycles, n + 2);
            check({tg, "_nxfer"}, xq.size(), n);
            for (int k = 0; k < n && xq.size() > 0; k++) begin
                x = xq.pop_front();
                check({tg, "_addr"}, x.addr, base + 64'(k * 8));
                check({tg, "_we"}, x.we, we);
                check({tg, "_wdata"}, x.wdata, wdata[k*64 +: 64]);
                check({tg, "_wmask"}, x.mask, is_vec ? 8'hFF : wmask);
            end
            xq.delete();
            if (!we) begin
                exp_rd = '0;
                for (int k = 0; k < n; k++) exp_rd[k*64 +: 64] = mem_rd(base + 64'(k * 8));
                if (is_vec) v_rd_model = exp_rd;
                else        s_rd_model = exp_rd[63:0];
            end
            if (is_vec) check("vec_rdata", v_rdata, v_rd_model);
            else        check("sca_rdata", s_rdata, s_rd_model);
            last_grant_vec = is_vec;
        end
        @(posedge clk); #1;
        if (is_vec) v_req = 1'b0;
        else        s_req = 1'b0;
    endtask

    task automatic run_pair(input bit swe, input logic [63:0] saddr, input logic [63:0] swdata,
                            input logic [7:0] swmask, input bit vwe, input logic [63:0] vaddr,
                            input logic [511:0] vwdata);
        time ts, tv;
        bit  exp_vec_first;
        exp_vec_first = !last_grant_vec;
        fork
            run_txn(1'b0, swe, saddr, {448'h0, swdata}, swmask, 1'b0, ts);
            run_txn(1'b1, vwe, vaddr, vwdata, 8'h00, 1'b0, tv);
        join
        check("pair_order_vec_first", (tv < ts), exp_vec_first);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time          t;
        int           cyc, mc, vacks;
        bit           got;
        logic [511:0] wd;
        reset = 1'b1;
        s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0; s_wmask = '0;
        v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mreq", m_req, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {s_ack, v_ack}, 0);
        check("rst_s_rdata", s_rdata, 0);
        check("rst_v_rdata", v_rdata, 0);
        check("rst_maddr", m_addr, 0);
`ifdef SIMD_ARB_TIMEOUT_EN
        check("rst_err", err, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        max_delay = 0;
        run_pair(1'b0, 64'h500, 64'h0, 8'h00, 1'b0, 64'h600, '0);

        mem[64'h1000] = 64'hDEAD_BEEF_CAFE_F00D;
        run_txn(1'b0, 1'b0, 64'h1004, '0, 8'hFF, 1'b1, t);
        check("t1_s_rdata", s_rdata, 64'hDEAD_BEEF_CAFE_F00D);

        run_pair(1'b1, 64'h700, 64'h1122_3344_5566_7788, 8'h0F, 1'b0, 64'h800, '0);

        for (int k = 0; k < BEATS; k++) wd[k*64 +: 64] = 64'(k);
        run_txn(1'b1, 1'b1, 64'h2000, wd, 8'h00, 1'b1, t);

        for (int k = 0; k < BEATS; k++) mem[64'h4000 + 64'(k * 8)] = 64'(k);
        max_delay = 5;
        run_txn(1'b1, 1'b0, 64'h4000, '0, 8'h00, 1'b1, t);
        for (int k = 0; k < BEATS; k++) check("t4_lane", v_rdata[k*64 +: 64], 64'(k));

        // Asynchronous reset while beat 3 of a vector read is outstanding.
        max_delay = 2;
        @(posedge clk); #1;
        v_we = 1'b0; v_addr = 64'h3000; v_req = 1'b1;
        cyc = 0;
        while (xq.size() < 3 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("t5_reach_beat3", xq.size(), 3);
        @(posedge clk); #2;
        check("t5_mreq_before", m_req, 1);
        reset = 1'b1;
        v_req = 1'b0;
        #1;
        check("t5_mreq_dropped", m_req, 0);
        check("t5_busy", busy, 0);
        check("t5_v_rdata", v_rdata, 0);
        vacks = 0;
        repeat (4) begin
            @(negedge clk);
            if (v_ack) vacks++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (v_ack) vacks++;
        end
        check("t5_no_vack", vacks, 0);
        xq.delete();
        last_grant_vec = 1'b1;
        s_rd_model = '0;
        v_rd_model = '0;
        max_delay = 0;
        run_txn(1'b0, 1'b0, 64'h1008, '0, 8'hFF, 1'b1, t);

`ifdef SIMD_ARB_TIMEOUT_EN
        hold_ack = 1'b1;
        @(posedge clk); #1;
        s_we = 1'b0; s_addr = 64'h40; s_req = 1'b1;
        cyc = 0; mc = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (s_ack) got = 1'b1;
            else if (m_req) mc++;
        end
        check("t6_ack", got, 1);
        check("t6_mreq_cycles", mc, 16);
        check("t6_s_rdata", s_rdata, 0);
        check("t6_err", err, 1);
        check("t6_nxfer", xq.size(), 0);
        @(posedge clk); #1;
        s_req = 1'b0;
        hold_ack = 1'b0;
        xq.delete();
        s_rd_model = '0;
        last_grant_vec = 1'b0;
        run_txn(1'b0, 1'b0, 64'h48, '0, 8'hFF, 1'b1, t);
        check("t6_err_sticky", err, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [63:0]  sa, va, sd;
            logic [511:0] vd;
            sa = ($urandom_range(0, 4) == 0) ? {56'hFFFF_FFFF_FFFF_FF, 8'($urandom)}
                                              : {52'h0, 12'($urandom)};
            va = ($urandom_range(0, 4) == 0) ? {56'hFFFF_FFFF_FFFF_FF, 8'($urandom)}
                                              : {52'h0, 12'($urandom)};
            sd = {$urandom, $urandom};
            for (int k = 0; k < 16; k++) vd[k*32 +: 32] = $urandom;
            max_delay = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 5);
            case ($urandom_range(0, 3))
                0: run_pair(1'($urandom), sa, sd, 8'($urandom), 1'($urandom), va, vd);
                1: run_txn(1'b1, 1'($urandom), va, vd, 8'h00, 1'b1, t);
                default: run_txn(1'b0, 1'($urandom), sa, {448'h0, sd}, 8'($urandom), 1'b1, t);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
